// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch stage. Holds the next-fetch PC and issues one
//   single-beat read at a time to instruction memory over a valid/ready
//   AR/R bus. Each returned word is presented to IF/ID with its PC and
//   fault flag until id_ready takes it.
//
//   A PC redirect (branch, jump or trap) overrides everything else.
//   If a request has already been issued, its response is marked stale
//   and discarded when it arrives.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   redirect_valid_i/pc_i   force the next fetch address
//   imem_ar*                read request channel (arvalid/arready/araddr)
//   imem_r*                 read response channel (rvalid/rready/rdata/rresp)
//   if_pc_o/inst_o/valid_o  instruction presented to IF/ID
//   if_fault_o              presented instruction came back with rresp != 0
//   id_ready_i              IF/ID accepts the presented instruction
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013,
   parameter int          ADDR_W     = 32,
   parameter int          DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              imem_arvalid_o,
   input  logic              imem_arready_i,
   output logic [ADDR_W-1:0] imem_araddr_o,
   input  logic              imem_rvalid_i,
   output logic              imem_rready_o,
   input  logic [DATA_W-1:0] imem_rdata_i,
   input  logic [1:0]        imem_rresp_i,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [DATA_W-1:0] if_inst_o,
   output logic              if_valid_o,
   output logic              if_fault_o,
   input  logic              id_ready_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t              state_q,    state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;   // next address to fetch
   logic [ADDR_W-1:0]   ar_addr_q,  ar_addr_d;    // address of the current request
   logic                drop_q,     drop_d;       // outstanding response is stale
   logic [ADDR_W-1:0]   out_pc_q,   out_pc_d;
   logic [DATA_W-1:0]   inst_q,     inst_d;
   logic                fault_q,    fault_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= ADDR_W'(RESET_ADDR);
         ar_addr_q  <= ADDR_W'(RESET_ADDR);
         drop_q     <= 1'b0;
         out_pc_q   <= ADDR_W'(RESET_ADDR);
         inst_q     <= DATA_W'(NOP_INST);
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         ar_addr_q  <= ar_addr_d;
         drop_q     <= drop_d;
         out_pc_q   <= out_pc_d;
         inst_q     <= inst_d;
         fault_q    <= fault_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      ar_addr_d      = ar_addr_q;
      drop_d         = drop_q;
      out_pc_d       = out_pc_q;
      inst_d         = inst_q;
      fault_d        = fault_q;
      imem_arvalid_o = 1'b0;
      imem_rready_o  = 1'b0;

      // A redirect always replaces the next-fetch PC; what else happens
      // depends on how far the current fetch has progressed.
      if (redirect_valid_i) begin
         fetch_pc_d = redirect_pc_i;
      end

      unique case (state_q)
         S_IDLE: begin
            ar_addr_d = redirect_valid_i ? redirect_pc_i : fetch_pc_q;
            state_d   = S_AR;
         end

         S_AR: begin
            // The request is already on the bus and must not be withdrawn,
            // so a redirect can only mark its eventual response stale.
            imem_arvalid_o = 1'b1;
            if (redirect_valid_i) begin
               drop_d = 1'b1;
            end
            if (imem_arready_i) begin
               state_d = S_R;
            end
         end

         S_R: begin
            imem_rready_o = 1'b1;
            if (imem_rvalid_i) begin
               if (redirect_valid_i) begin
                  drop_d    = 1'b0;
                  ar_addr_d = redirect_pc_i;
                  state_d   = S_AR;
               end else if (drop_q) begin
                  drop_d    = 1'b0;
                  ar_addr_d = fetch_pc_q;
                  state_d   = S_AR;
               end else begin
                  inst_d     = imem_rdata_i;
                  out_pc_d   = ar_addr_q;
                  fault_d    = (imem_rresp_i != 2'b00);
                  fetch_pc_d = ar_addr_q + ADDR_W'(4);
                  state_d    = S_OUT;
               end
            end else if (redirect_valid_i) begin
               drop_d = 1'b1;
            end
         end

         S_OUT: begin
            if (redirect_valid_i) begin
               ar_addr_d = redirect_pc_i;
               state_d   = S_AR;
            end else if (id_ready_i) begin
               ar_addr_d = fetch_pc_q;
               state_d   = S_AR;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imem_araddr_o = ar_addr_q;

   // A redirect in the same cycle kills the presented instruction
   // combinationally so IF/ID never latches a wrong-path word.
   assign if_valid_o = (state_q == S_OUT) && !redirect_valid_i;
   assign if_pc_o    = out_pc_q;
   assign if_inst_o  = if_valid_o ? inst_q : DATA_W'(NOP_INST);
   assign if_fault_o = if_valid_o && fault_q;

endmodule
